// File: rtl/sw_job_scheduler_pkg.sv
// Shared definitions for the SmithWaterman job scheduler: default widths,
// FSM state encoding and descriptor sizing.
package sw_job_scheduler_pkg;

  localparam int unsigned SW_MATCH_BIT  = 8;
  localparam int unsigned SW_CALC_BIT   = 16;
  localparam int unsigned SW_IDX_BIT    = 8;
  localparam int unsigned DRAIN_CYC_DEF = 8;
  localparam int unsigned WAKE_TMO_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAKE   = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_EMIT   = 3'd5
  } sched_state_e;

  // Descriptor = four scoring magnitudes followed by the tag.
  function automatic int unsigned desc_width(input int unsigned match_bit,
                                             input int unsigned tag_bit);
    return 4 * match_bit + tag_bit;
  endfunction

endpackage

// File: rtl/sw_job_scheduler_if.sv
// Scheduler <-> SmithWaterman core control/result bundle.
interface sw_job_scheduler_if #(
  parameter int unsigned MATCH_BIT = sw_job_scheduler_pkg::SW_MATCH_BIT,
  parameter int unsigned CALC_BIT  = sw_job_scheduler_pkg::SW_CALC_BIT,
  parameter int unsigned IDX_BIT   = sw_job_scheduler_pkg::SW_IDX_BIT
);
  logic                 sw_start_o;
  logic [MATCH_BIT-1:0] sw_match_o;
  logic [MATCH_BIT-1:0] sw_mismatch_o;
  logic [MATCH_BIT-1:0] sw_alpha_o;
  logic [MATCH_BIT-1:0] sw_beta_o;
  logic                 sw_busy_i;
  logic                 sw_valid_i;
  logic [CALC_BIT-1:0]  sw_max_i;
  logic [IDX_BIT-1:0]   sw_idx_i;
  logic                 sw_change_q_i;

  modport master (
    output sw_start_o, sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o,
    input  sw_busy_i, sw_valid_i, sw_max_i, sw_idx_i, sw_change_q_i
  );

  modport slave (
    input  sw_start_o, sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o,
    output sw_busy_i, sw_valid_i, sw_max_i, sw_idx_i, sw_change_q_i
  );
endinterface

// File: rtl/sw_job_fifo.sv
// Synchronous job descriptor FIFO with registered count, ready and empty flags.
module sw_job_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign push = wr_en_i & wr_ready_o;
  assign pop  = rd_en_i & ~empty_o;

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Flags are derived from the next count so they are plain registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_o <= 1'b1;
      empty_o    <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      wr_ready_o <= (count_d != CW'(DEPTH));
      empty_o    <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_c = mem[rd_ptr_q];

endmodule

// File: rtl/sw_job_scheduler.sv
// Batch controller: queues alignment jobs, launches them on the SmithWaterman
// core one at a time and emits one tracked result record per job.
module sw_job_scheduler
  import sw_job_scheduler_pkg::*;
#(
  parameter int unsigned MATCH_BIT = SW_MATCH_BIT,
  parameter int unsigned CALC_BIT  = SW_CALC_BIT,
  parameter int unsigned IDX_BIT   = SW_IDX_BIT,
  parameter int unsigned TAG_BIT   = 4,
  parameter int unsigned JOB_DEPTH = 4,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int unsigned WAKE_TMO  = WAKE_TMO_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [MATCH_BIT-1:0] job_match_i,
  input  logic [MATCH_BIT-1:0] job_mismatch_i,
  input  logic [MATCH_BIT-1:0] job_alpha_i,
  input  logic [MATCH_BIT-1:0] job_beta_i,
  input  logic [TAG_BIT-1:0]   job_tag_i,
  sw_job_scheduler_if.master   core,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [TAG_BIT-1:0]   res_tag_o,
  output logic [CALC_BIT-1:0]  res_score_o,
  output logic [IDX_BIT-1:0]   res_idx_o,
  output logic [7:0]           res_nq_o,
  output logic                 res_err_o,
  output logic [15:0]          jobs_done_o
);
  localparam int unsigned DESC_W = desc_width(MATCH_BIT, TAG_BIT);
  localparam int unsigned DCW    = $clog2(DRAIN_CYC + 1);
  localparam int unsigned TCW    = $clog2(WAKE_TMO + 1);

  sched_state_e         state_q, state_d;
  logic                 pop, tmo_fire, accept, track;
  logic                 fifo_empty;
  logic [DESC_W-1:0]    fifo_head;
  logic [MATCH_BIT-1:0] hd_match, hd_mismatch, hd_alpha, hd_beta;
  logic [TAG_BIT-1:0]   hd_tag;
  logic [DCW-1:0]       drain_cnt_q;
  logic [TCW-1:0]       tmo_cnt_q;

  sw_job_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (JOB_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (job_valid_i),
    .wr_data_i  ({job_match_i, job_mismatch_i, job_alpha_i, job_beta_i, job_tag_i}),
    .wr_ready_o (job_ready_o),
    .rd_en_i    (pop),
    .rd_data_c  (fifo_head),
    .empty_o    (fifo_empty)
  );

  assign {hd_match, hd_mismatch, hd_alpha, hd_beta, hd_tag} = fifo_head;

  assign track  = (state_q == ST_WAKE) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign accept = (state_q == ST_EMIT) && res_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; busy re-rising always wins over drain/timeout expiry.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    tmo_fire = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i && !fifo_empty) begin
          state_d = ST_LAUNCH;
          pop     = 1'b1;
        end
      end
      ST_LAUNCH: state_d = ST_WAKE;
      ST_WAKE: begin
        if (core.sw_busy_i) begin
          state_d = ST_RUN;
        end else if (tmo_cnt_q == TCW'(WAKE_TMO - 1)) begin
          state_d  = ST_EMIT;
          tmo_fire = 1'b1;
        end
      end
      ST_RUN: begin
        if (!core.sw_busy_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (core.sw_busy_i)                             state_d = ST_RUN;
        else if (drain_cnt_q == DCW'(DRAIN_CYC - 1))    state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Launch parameters, result tracking and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core.sw_start_o    <= 1'b0;
      core.sw_match_o    <= '0;
      core.sw_mismatch_o <= '0;
      core.sw_alpha_o    <= '0;
      core.sw_beta_o     <= '0;
      res_valid_o        <= 1'b0;
      res_tag_o          <= '0;
      res_score_o        <= '0;
      res_idx_o          <= '0;
      res_nq_o           <= '0;
      res_err_o          <= 1'b0;
      jobs_done_o        <= '0;
      drain_cnt_q        <= '0;
      tmo_cnt_q          <= '0;
    end else begin
      core.sw_start_o <= (state_d == ST_LAUNCH);
      res_valid_o     <= (state_d == ST_EMIT);

      if (pop) begin
        core.sw_match_o    <= hd_match;
        core.sw_mismatch_o <= hd_mismatch;
        core.sw_alpha_o    <= hd_alpha;
        core.sw_beta_o     <= hd_beta;
        res_tag_o          <= hd_tag;
        res_score_o        <= '0;
        res_idx_o          <= '0;
        res_nq_o           <= '0;
        res_err_o          <= 1'b0;
      end else if (track) begin
        if (core.sw_valid_i && (core.sw_max_i > res_score_o)) begin
          res_score_o <= core.sw_max_i;
          res_idx_o   <= core.sw_idx_i;
        end
        if (core.sw_change_q_i && (res_nq_o != 8'hFF)) res_nq_o <= res_nq_o + 8'd1;
        if (tmo_fire) res_err_o <= 1'b1;
      end

      tmo_cnt_q   <= (state_q == ST_WAKE)  ? tmo_cnt_q + TCW'(1)   : '0;
      drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + DCW'(1) : '0;

      if (accept) jobs_done_o <= jobs_done_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Randomized self-checking bench for sw_job_scheduler with a timing-level
// reference model of job launch, result tracking windows and result handshake.
module tb_sw_job_scheduler;
  import sw_job_scheduler_pkg::*;

  localparam int unsigned MB    = 8;
  localparam int unsigned CB    = 16;
  localparam int unsigned IB    = 8;
  localparam int unsigned TB    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DRAIN = 8;
  localparam int unsigned TMO   = 4;

  typedef struct packed {
    logic [MB-1:0] m;
    logic [MB-1:0] mm;
    logic [MB-1:0] a;
    logic [MB-1:0] b;
    logic [TB-1:0] tag;
  } job_t;

  typedef struct {
    int tag;
    int score;
    int idx;
    int nq;
    int err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_i, job_valid_i, job_ready_o, res_valid_o, res_ready_i, res_err_o;
  logic [MB-1:0] job_match_i, job_mismatch_i, job_alpha_i, job_beta_i;
  logic [TB-1:0] job_tag_i, res_tag_o;
  logic [CB-1:0] res_score_o;
  logic [IB-1:0] res_idx_o;
  logic [7:0]    res_nq_o;
  logic [15:0]   jobs_done_o;

  sw_job_scheduler_if #(.MATCH_BIT(MB), .CALC_BIT(CB), .IDX_BIT(IB)) core_if ();

  sw_job_scheduler #(
    .MATCH_BIT(MB), .CALC_BIT(CB), .IDX_BIT(IB), .TAG_BIT(TB),
    .JOB_DEPTH(DEPTH), .DRAIN_CYC(DRAIN), .WAKE_TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_match_i(job_match_i), .job_mismatch_i(job_mismatch_i),
    .job_alpha_i(job_alpha_i), .job_beta_i(job_beta_i), .job_tag_i(job_tag_i),
    .core(core_if),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_tag_o(res_tag_o), .res_score_o(res_score_o), .res_idx_o(res_idx_o),
    .res_nq_o(res_nq_o), .res_err_o(res_err_o), .jobs_done_o(jobs_done_o)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;
  job_t job_q[$];
  res_t exp_q[$];
  bit   halt = 0, drv_on = 0, direct_req = 0, long_req = 0;
  int   job_pct = 40, ready_pct = 70;
  int   starts = 0, pushed_n = 0, done_n = 0, direct_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_job_ready", job_ready_o, 1);
    check_eq("rst_start", core_if.sw_start_o, 0);
    check_eq("rst_match", core_if.sw_match_o, 0);
    check_eq("rst_mismatch", core_if.sw_mismatch_o, 0);
    check_eq("rst_alpha", core_if.sw_alpha_o, 0);
    check_eq("rst_beta", core_if.sw_beta_o, 0);
    check_eq("rst_res_valid", res_valid_o, 0);
    check_eq("rst_res_tag", res_tag_o, 0);
    check_eq("rst_res_score", res_score_o, 0);
    check_eq("rst_res_idx", res_idx_o, 0);
    check_eq("rst_res_nq", res_nq_o, 0);
    check_eq("rst_res_err", res_err_o, 0);
    check_eq("rst_jobs_done", jobs_done_o, 0);
  endtask

  // Job source: random or directed descriptors, plus job_ready occupancy model.
  initial begin
    int   seen;
    job_t j;
    seen = 0;
    job_valid_i = 0;
    {job_match_i, job_mismatch_i, job_alpha_i, job_beta_i, job_tag_i} = '0;
    forever begin
      @(negedge clk);
      job_valid_i = 0;
      if (halt || !rst_n) continue;
      if (core_if.sw_start_o) seen++;
      check_eq("job_ready", job_ready_o, (pushed_n - seen) != int'(DEPTH));
      if (direct_req) begin
        j = '{m: MB'(3), mm: MB'(1), a: MB'(2), b: MB'(1), tag: TB'(5)};
        direct_req = 0;
        direct_cyc = cyc;
        job_valid_i = 1;
      end else if (drv_on && ($urandom % 100) < job_pct) begin
        j = '{m: MB'($urandom), mm: MB'($urandom), a: MB'($urandom),
              b: MB'($urandom), tag: TB'($urandom)};
        job_valid_i = 1;
      end
      {job_match_i, job_mismatch_i, job_alpha_i, job_beta_i, job_tag_i} = j;
      if (job_valid_i && job_ready_o) begin
        pushed_n++;
        job_q.push_back(j);
      end
    end
  end

  // Core model: one run per start pulse; expected record built from the
  // events that fall inside the job's tracking window.
  task automatic run_job();
    job_t j;
    res_t r;
    bit   err, lng, v, cq;
    int   d, len, b, lastk, mx;
    starts++;
    if (job_q.size() == 0) begin
      check_eq("start_unexpected", 1, 0);
      return;
    end
    j = job_q.pop_front();
    check_eq("sw_match", core_if.sw_match_o, j.m);
    check_eq("sw_mismatch", core_if.sw_mismatch_o, j.mm);
    check_eq("sw_alpha", core_if.sw_alpha_o, j.a);
    check_eq("sw_beta", core_if.sw_beta_o, j.b);
    lng = long_req;
    long_req = 0;
    err = !lng && (($urandom % 6) == 0);
    d   = $urandom_range(0, TMO - 1);
    len = lng ? 300 : $urandom_range(1, 15);
    b   = 1 + d + len;
    lastk = err ? TMO : b + DRAIN;
    r = '{tag: int'(j.tag), score: 0, idx: 0, nq: 0, err: int'(err)};
    for (int k = 1; k <= lastk + 1; k++) begin
      @(negedge clk);
      if (halt || !rst_n) return;
      core_if.sw_busy_i = !err && (k >= 1 + d) && (k < b);
      v  = (k == lastk + 1) || (($urandom % 100) < 35);
      mx = (k == lastk + 1) ? 255 : $urandom_range(0, 15);
      cq = lng || (($urandom % 100) < 30);
      core_if.sw_valid_i    = v;
      core_if.sw_max_i      = CB'(mx);
      core_if.sw_idx_i      = IB'($urandom_range(0, 255));
      core_if.sw_change_q_i = cq;
      if (k <= lastk) begin
        if (v && mx > r.score) begin
          r.score = mx;
          r.idx   = int'(core_if.sw_idx_i);
        end
        if (cq && r.nq < 255) r.nq++;
      end
      check_eq("start_single_pulse", core_if.sw_start_o, 0);
      if (k == lastk) begin
        check_eq("res_valid_early", res_valid_o, 0);
        exp_q.push_back(r);
      end
      if (k == lastk + 1) check_eq("res_valid_latency", res_valid_o, 1);
    end
  endtask

  initial begin
    core_if.sw_busy_i = 0; core_if.sw_valid_i = 0; core_if.sw_max_i = '0;
    core_if.sw_idx_i = '0; core_if.sw_change_q_i = 0;
    forever begin
      @(negedge clk);
      core_if.sw_busy_i = 0; core_if.sw_valid_i = 0; core_if.sw_change_q_i = 0;
      if (halt || !rst_n) continue;
      if (core_if.sw_start_o) run_job();
    end
  end

  // Result consumer with random backpressure.
  initial begin
    res_t r;
    res_ready_i = 0;
    forever begin
      @(negedge clk);
      res_ready_i = 0;
      if (halt || !rst_n) continue;
      check_eq("jobs_done", jobs_done_o, done_n & 16'hFFFF);
      if (res_valid_o) begin
        check_eq("start_during_emit", core_if.sw_start_o, 0);
        if (exp_q.size() == 0) begin
          check_eq("res_unexpected", 1, 0);
        end else begin
          r = exp_q[0];
          check_eq("res_tag", res_tag_o, r.tag);
          check_eq("res_score", res_score_o, r.score);
          check_eq("res_idx", res_idx_o, r.idx);
          check_eq("res_nq", res_nq_o, r.nq);
          check_eq("res_err", res_err_o, r.err);
          res_ready_i = ($urandom % 100) < ready_pct;
          if (res_ready_i) begin
            void'(exp_q.pop_front());
            done_n++;
          end
        end
      end
    end
  end

  task automatic wait_all(input int limit);
    int n = 0;
    while (!(done_n == pushed_n && !res_valid_o) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("all_jobs_done", done_n == pushed_n, 1);
  endtask

  initial begin
    int s0, first_start, n_start, n;
    en_i = 0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1;

    // Directed push into an idle, empty scheduler: start two cycles later.
    en_i = 1;
    @(posedge clk);
    direct_req = 1;
    n_start = 0;
    first_start = -1;
    repeat (8) begin
      @(negedge clk);
      if (core_if.sw_start_o) begin
        n_start++;
        if (first_start < 0) first_start = cyc;
      end
    end
    check_eq("start_count", n_start, 1);
    check_eq("push_to_start", first_start - direct_cyc, 2);
    wait_all(2000);

    // Random traffic, including one long job that saturates nq.
    long_req = 1;
    job_pct = 40; ready_pct = 70; drv_on = 1;
    repeat (1500) @(negedge clk);
    drv_on = 0;
    repeat (2) @(negedge clk);
    wait_all(4000);

    // Fill to depth with launching disabled.
    en_i = 0;
    job_pct = 100; drv_on = 1;
    repeat (10) @(negedge clk);
    drv_on = 0;
    s0 = starts;
    repeat (20) @(negedge clk);
    check_eq("fifo_full_ready", job_ready_o, 0);
    check_eq("no_start_when_disabled", starts, s0);
    en_i = 1;
    wait_all(4000);

    // Backpressure holds EMIT; then disable while the record is pending.
    ready_pct = 0; job_pct = 100; drv_on = 1;
    repeat (2) @(negedge clk);
    drv_on = 0;
    n = 0;
    while (!res_valid_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_res_valid_seen", res_valid_o, 1);
    s0 = starts;
    repeat (50) @(negedge clk);
    check_eq("bp_res_valid_held", res_valid_o, 1);
    check_eq("bp_no_new_start", starts, s0);
    en_i = 0;
    ready_pct = 100;
    repeat (100) @(negedge clk);
    check_eq("dis_no_launch", starts, s0);
    check_eq("dis_res_valid_low", res_valid_o, 0);
    en_i = 1;
    ready_pct = 70;
    wait_all(4000);

    // Reset in the middle of a running job.
    long_req = 1; job_pct = 100; drv_on = 1;
    @(negedge clk);
    drv_on = 0;
    n = 0;
    while (!core_if.sw_busy_i && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_before_reset", core_if.sw_busy_i, 1);
    @(posedge clk);
    #1;
    halt = 1;
    rst_n = 0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1;
    n_start = 0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (core_if.sw_start_o) n_start++;
      if (res_valid_o) n++;
    end
    check_eq("post_reset_no_start", n_start, 0);
    check_eq("post_reset_no_result", n, 0);
    check_eq("post_reset_ready", job_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
